// File: rtl/synth_spi_pkg.sv
// synth_spi_pkg: shared constants, FSM states and frame builder for the voice SPI master
package synth_spi_pkg;
  localparam logic [7:0] CMD_WRITE_DIV = 8'h80;
  localparam int FRAME_BITS = 24;
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] voice, input logic [15:0] div);
    return {CMD_WRITE_DIV | voice, div};
  endfunction
endpackage

// File: rtl/spi_half_tick.sv
// spi_half_tick: one-cycle tick every CLK_DIV cycles, realigned by a synchronous restart
module spi_half_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = cnt == '0;

  // count down to zero, reloading on every tick or restart
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= RELOAD;
    else cnt <= (restart || tick) ? RELOAD : cnt - 1'b1;
endmodule

// File: rtl/voice_cmd_spi_master.sv
// voice_cmd_spi_master: mode-0 SPI master sending 3-byte voice-divider write frames
module voice_cmd_spi_master
  import synth_spi_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int D_W        = 16,
  parameter int BYTE_W     = 8,
  parameter int CLK_DIV    = 4,
  parameter int GAP_HALF   = 2
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [$clog2(NUM_VOICES)-1:0] cmd_voice,
  input  logic [D_W-1:0]                cmd_div,
  output logic                          spi_sck,
  output logic                          spi_csn,
  output logic                          spi_mosi,
  input  logic                          spi_miso,
  output logic [3*BYTE_W-1:0]           rx_data,
  output logic                          rx_valid,
  output logic                          busy
);
  localparam logic [4:0] GAP_LAST = 5'(GAP_HALF - 1);

  state_t                  state;
  logic                    tick;
  logic [FRAME_BITS-1:0]   frame;
  logic [FRAME_BITS-2:0]   tx_sh;
  logic [FRAME_BITS-1:0]   rx_sh;
  logic [4:0]              bit_cnt;

  assign frame = build_frame(8'(cmd_voice), 16'(cmd_div));

  // the tick counter is held in restart while idle so SETUP lasts exactly CLK_DIV cycles
  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (sys_clk),
    .rst_n  (rst_n),
    .restart(state == IDLE),
    .tick   (tick)
  );

  // frame sequencer: bit23 is driven straight from the accept, the rest comes from tx_sh
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      spi_sck   <= 1'b0;
      spi_csn   <= 1'b1;
      spi_mosi  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      bit_cnt   <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE:
          if (cmd_valid && cmd_ready) begin
            tx_sh     <= frame[FRAME_BITS-2:0];
            spi_mosi  <= frame[FRAME_BITS-1];
            spi_csn   <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            state     <= SETUP;
          end
        SETUP:
          if (tick) state <= SHIFT;
        SHIFT:
          if (tick) begin
            if (!spi_sck) begin
              spi_sck <= 1'b1;
              rx_sh   <= {rx_sh[FRAME_BITS-2:0], spi_miso};
            end else begin
              spi_sck <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= HOLD;
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                spi_mosi <= tx_sh[FRAME_BITS-2];
                tx_sh    <= {tx_sh[FRAME_BITS-3:0], 1'b0};
              end
            end
          end
        HOLD:
          if (tick) begin
            spi_csn  <= 1'b1;
            spi_mosi <= 1'b0;
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
            state    <= GAP;
          end
        GAP:
          if (tick) begin
            if (bit_cnt == GAP_LAST) begin
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else bit_cnt <= bit_cnt + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_voice_cmd_spi_master.sv
// tb_voice_cmd_spi_master: directed vectors and corner sequences for the voice SPI master
module tb_voice_cmd_spi_master;
  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, busy;
  logic [1:0]  cmd_voice = '0;
  logic [15:0] cmd_div = '0;
  logic        spi_sck, spi_csn, spi_mosi, spi_miso, rx_valid;
  logic [23:0] rx_data;
  logic        lb = 1'b0;

  logic        c1_valid = 1'b0, c1_ready, c1_busy;
  logic [1:0]  c1_voice = '0;
  logic [15:0] c1_div = '0;
  logic        s1_sck, s1_csn, s1_mosi, s1_rx_valid;
  logic [23:0] s1_rx_data;

  int n_cmp = 0, n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  assign spi_miso = lb ? spi_mosi : 1'b0;

  voice_cmd_spi_master dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_voice(cmd_voice), .cmd_div(cmd_div), .spi_sck(spi_sck), .spi_csn(spi_csn),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  voice_cmd_spi_master #(.CLK_DIV(1)) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_voice(c1_voice), .cmd_div(c1_div), .spi_sck(s1_sck), .spi_csn(s1_csn),
    .spi_mosi(s1_mosi), .spi_miso(1'b0), .rx_data(s1_rx_data), .rx_valid(s1_rx_valid), .busy(c1_busy)
  );

  // slave-side observers, sampled on the falling sys_clk edge
  int          cyc = 0, csn_low, rises, vcnt, coin_bad, rdy_low, busy_err = 0, nfalls, nframes;
  int          fall_t[4], rise_t[4];
  logic [23:0] cap, rx_cap;
  logic [23:0] frames[4];
  logic        sck_q = 1'b0, csn_q = 1'b1;
  int          m1_low, m1_rises, m1_bad, m1_last;
  logic [23:0] m1_cap;
  logic        s1_sck_q = 1'b0;

  task automatic clear_mon();
    csn_low = 0; rises = 0; vcnt = 0; coin_bad = 0; rdy_low = 0; nfalls = 0; nframes = 0;
    cap = '0; rx_cap = '0;
    for (int i = 0; i < 4; i++) begin frames[i] = '0; fall_t[i] = 0; rise_t[i] = 0; end
    m1_low = 0; m1_rises = 0; m1_bad = 0; m1_last = -1; m1_cap = '0;
  endtask

  always @(negedge sys_clk) begin
    cyc++;
    if (!spi_csn) csn_low++;
    if (!cmd_ready) rdy_low++;
    if (busy !== !cmd_ready) busy_err++;
    if (spi_sck && !sck_q && !spi_csn) begin cap = {cap[22:0], spi_mosi}; rises++; end
    if (!spi_csn && csn_q) begin
      cap = '0;
      if (nfalls < 4) fall_t[nfalls] = cyc;
      nfalls++;
    end
    if (spi_csn && !csn_q) begin
      if (nframes < 4) begin frames[nframes] = cap; rise_t[nframes] = cyc; end
      nframes++;
    end
    if (rx_valid) begin
      vcnt++;
      rx_cap = rx_data;
      if (!(spi_csn && !csn_q)) coin_bad++;
    end
    sck_q = spi_sck;
    csn_q = spi_csn;
    if (!s1_csn) m1_low++;
    if (s1_sck && !s1_sck_q && !s1_csn) begin
      m1_cap = {m1_cap[22:0], s1_mosi};
      m1_rises++;
      if (m1_last >= 0 && cyc - m1_last != 2) m1_bad++;
      m1_last = cyc;
    end
    s1_sck_q = s1_sck;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting, expected event", name);
  endtask

  task automatic wait_ready(input string name);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(posedge sys_clk); #1;
      if (cmd_ready) break;
    end
    if (k == 2000) timeout(name);
  endtask

  task automatic run_cmd(input logic [1:0] v, input logic [15:0] d, input logic l);
    @(posedge sys_clk); #1;
    clear_mon();
    lb = l; cmd_voice = v; cmd_div = d; cmd_valid = 1'b1;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    wait_ready("frame_done");
  endtask

  typedef struct {
    logic [1:0]  voice;
    logic [15:0] div;
    logic        lb;
    logic [23:0] exp_frame;
    logic [23:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{2'd2, 16'h01D6, 1'b0, 24'h8201D6, 24'h000000};
    vecs[1] = '{2'd2, 16'h01D6, 1'b1, 24'h8201D6, 24'h8201D6};
    vecs[2] = '{2'd3, 16'h0004, 1'b0, 24'h830004, 24'h000000};
    vecs[3] = '{2'd1, 16'h1234, 1'b1, 24'h811234, 24'h811234};
    clear_mon();
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_ctl", {cmd_ready, busy, spi_csn, spi_sck, spi_mosi, rx_valid}, 6'b101000);
    check("reset_rx", rx_data, 24'h0);
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check("post_reset_ctl", {cmd_ready, busy, spi_csn, spi_sck, spi_mosi, rx_valid}, 6'b101000);

    for (int i = 0; i < 4; i++) begin
      run_cmd(vecs[i].voice, vecs[i].div, vecs[i].lb);
      check($sformatf("v%0d_frame", i), frames[0], vecs[i].exp_frame);
      check($sformatf("v%0d_rises", i), rises, 24);
      check($sformatf("v%0d_csn_low", i), csn_low, 200);
      check($sformatf("v%0d_rx_pulses", i), vcnt, 1);
      check($sformatf("v%0d_rx_data", i), rx_cap, vecs[i].exp_rx);
      check($sformatf("v%0d_rx_coincident", i), coin_bad, 0);
      check($sformatf("v%0d_ready_low", i), rdy_low, 208);
    end

    // back-to-back with cmd_valid held and data churning during the first frame
    @(posedge sys_clk); #1;
    clear_mon();
    lb = 1'b0; cmd_voice = 2'd2; cmd_div = 16'h01D6; cmd_valid = 1'b1;
    @(posedge sys_clk); #1;
    for (int i = 0; i < 150; i++) begin
      cmd_voice = 2'($urandom);
      cmd_div = 16'($urandom);
      @(posedge sys_clk); #1;
    end
    check("b2b_no_early_frame", nfalls, 1);
    cmd_voice = 2'd3; cmd_div = 16'h0004;
    begin
      int k;
      for (k = 0; k < 500; k++) begin
        @(posedge sys_clk); #1;
        if (nfalls >= 2) break;
      end
      if (k == 500) timeout("b2b_second_fall");
    end
    cmd_valid = 1'b0;
    wait_ready("b2b_done");
    check("b2b_frame0", frames[0], 24'h8201D6);
    check("b2b_frame1", frames[1], 24'h830004);
    check("b2b_gap", fall_t[1] - rise_t[0], 9);
    check("b2b_falls", nfalls, 2);
    check("b2b_ready_low", rdy_low, 416);

    // reset mid-frame after the 10th SCK rise
    @(posedge sys_clk); #1;
    clear_mon();
    lb = 1'b1; cmd_voice = 2'd2; cmd_div = 16'h01D6; cmd_valid = 1'b1;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    begin
      int k;
      for (k = 0; k < 500; k++) begin
        @(negedge sys_clk);
        if (rises >= 10) break;
      end
      if (k == 500) timeout("rst_wait_rises");
    end
    #1 rst_n = 1'b0;
    #1 check("rst_pins", {spi_csn, spi_sck, spi_mosi}, 3'b100);
    repeat (3) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check("rst_ready", {cmd_ready, busy}, 2'b10);
    check("rst_no_valid", vcnt, 0);
    check("rst_rx_data", rx_data, 24'h0);
    run_cmd(2'd0, 16'hFFFF, 1'b1);
    check("rst_next_frame", frames[0], 24'h80FFFF);
    check("rst_next_rises", rises, 24);
    check("rst_next_rx", rx_cap, 24'h80FFFF);

    // CLK_DIV=1 instance
    @(posedge sys_clk); #1;
    clear_mon();
    c1_voice = 2'd1; c1_div = 16'h1234; c1_valid = 1'b1;
    @(posedge sys_clk); #1;
    c1_valid = 1'b0;
    begin
      int k;
      for (k = 0; k < 200; k++) begin
        @(posedge sys_clk); #1;
        if (c1_ready) break;
      end
      if (k == 200) timeout("div1_done");
    end
    check("div1_frame", m1_cap, 24'h811234);
    check("div1_csn_low", m1_low, 50);
    check("div1_rises", m1_rises, 24);
    check("div1_period", m1_bad, 0);

    check("busy_tracks_ready", busy_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/voice_cmd_spi_master.md
Name: voice_cmd_spi_master

Overview:
- SPI mode-0 master that serializes voice-divider write commands into 3-byte frames, and captures MISO.
- It is the initiator for the synth's SPI voice-control slave. It drives that slave's SCK/~CS/MOSI pads for on-board sequencing and for loopback bring-up.
- It sits on the 48 MHz system clock domain and accepts one command per frame through a valid/ready handshake.

Parameters:
- NUM_VOICES, 4, number of voices; voice field width VW = $clog2(NUM_VOICES).
- D_W, 16, divider width; fixed at 2 bytes.
- BYTE_W, 8, bits per SPI byte.
- CLK_DIV, 4, SCK half-period in sys_clk cycles; minimum 1. The default gives SCK = 6 MHz.
- GAP_HALF, 2, minimum ~CS-high gap between frames, in SCK half-periods.

Ports:
- sys_clk  in  1  48 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_voice  in  VW  target voice index.
- cmd_div  in  D_W  NCO divider value for that voice.
- spi_sck  out  1  SPI clock; CPOL=0.
- spi_csn  out  1  chip select, active low.
- spi_mosi  out  1  serial data out, MSB first.
- spi_miso  in  1  serial data in.
- rx_data  out  3*BYTE_W  bytes shifted in during the last frame; the first byte received is in the MSBs.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high from command accept until the end of the gap.

Behaviour:
- Reset values (asserted asynchronously):
  - cmd_ready=1, spi_sck=0, spi_csn=1, spi_mosi=0.
  - rx_data=0, rx_valid=0, busy=0.
  - State returns to IDLE.
  - Reset mid-frame aborts the frame immediately; no rx_valid is generated.
- Frame format, 24 bits MSB first:
  - byte0 = 0x80 | cmd_voice (zero-extended).
  - byte1 = cmd_div[15:8].
  - byte2 = cmd_div[7:0].
  - Divider values are sent unmodified; values below 4 are the slave's problem.
- Handshake:
  - A transfer occurs on a sys_clk edge where cmd_valid && cmd_ready.
  - Voice and divider are latched into a 24-bit shift register at that edge.
  - cmd_ready drops the next cycle and stays low through the frame and the gap.
  - cmd_valid and data changes while busy are ignored.
- States:
  - IDLE: accept a command, then go to SETUP.
  - SETUP: spi_csn=0 and spi_mosi=bit23 from accept+1. Wait CLK_DIV cycles, then go to SHIFT.
  - SHIFT: toggle spi_sck every CLK_DIV cycles, giving 48 half-periods.
    - Rising edge: sample spi_miso into the rx shift register.
    - Falling edge: shift and present the next MOSI bit.
    - After the 24th falling edge, go to HOLD; spi_mosi stays at bit0.
  - HOLD: wait CLK_DIV cycles, then spi_csn=1, spi_mosi=0, rx_data updates, rx_valid pulses for that one cycle. Go to GAP.
  - GAP: wait GAP_HALF*CLK_DIV cycles, then go to IDLE with cmd_ready=1.
- Timing:
  - spi_csn is low for exactly 50*CLK_DIV cycles.
  - The next spi_csn fall is at least GAP_HALF*CLK_DIV+1 cycles after spi_csn rises.
- Counters:
  - Half-period counter is $clog2(CLK_DIV+1) bits and reloads on every tick.
  - Bit counter is 5 bits and counts 0..23; there is no wrap beyond 23.
- spi_sck idles low outside SHIFT. There are no SCK glitches at state boundaries.
- All outputs are registered.
- busy = !cmd_ready.

Decomposition:
- Package synth_spi_pkg holds:
  - CMD_WRITE_DIV = 8'h80 and FRAME_BITS = 24.
  - The state enum {IDLE, SETUP, SHIFT, HOLD, GAP}.
  - The helper function that builds the frame from voice and div.
- One natural sub-module is spi_half_tick: a CLK_DIV counter producing a one-cycle tick with a synchronous restart input. The FSM and shift registers stay in the top.

Test Plan:
- Voice 2, div 0x01D6 (470), CLK_DIV=4: the slave model samples MOSI on SCK rises and sees 0x82, 0x01, 0xD6. There are exactly 24 SCK rises, and spi_csn is low for 200 cycles.
- spi_miso tied to spi_mosi (loopback), same command: rx_data=0x8201D6. rx_valid is a single pulse, coincident with the spi_csn rise.
- cmd_valid held high with a second command queued (voice 3, div 0x0004): cmd_ready is low for the frame plus gap. The second spi_csn fall is 9 cycles after the first spi_csn rise. The second frame bytes are 0x83, 0x00, 0x04.
- rst_n asserted after the 10th SCK rise: spi_csn=1, spi_sck=0, spi_mosi=0 in the same cycle, and no rx_valid. After release, cmd_ready=1, and the next command (voice 0, div 0xFFFF) yields a clean frame 0x80, 0xFF, 0xFF.
- CLK_DIV=1, voice 1, div 0x1234: SCK period is 2 cycles, spi_csn is low for 50 cycles, and bytes are 0x81, 0x12, 0x34.
- cmd_voice/cmd_div toggled with cmd_valid=1 during a frame: the in-flight MOSI bits are unchanged, and no extra frame is started until cmd_ready returns.
